// File: rtl/rdma_rx_pkt_buf.sv
// rdma_rx_pkt_buf -- store-and-forward RX packet buffer.
//
// Beats arrive from a link that cannot be stalled. Each beat is written
// speculatively into a circular buffer. A packet becomes visible downstream
// only when its last beat is stored without error. Errored packets and
// packets that do not fit are rewound and discarded as a whole, and each
// discarded packet is counted once.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   rx_valid/rx_data/rx_last   incoming beat (no backpressure)
//   rx_err                     packet error, meaningful only on the last beat
//   out_valid/out_data/out_last/out_ready   committed beats, valid/ready
//   drop_pulse                 one-cycle pulse per dropped packet
//   pkt_cnt, drop_cnt          committed / dropped packet counters (wrapping)
//   level                      committed beats currently held
module rdma_rx_pkt_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_last,
    input  logic                     rx_err,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;  // one extra bit separates full from empty

    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;   // speculative write end
    logic [PW-1:0]     cmt_ptr_q, cmt_ptr_d; // end of committed packets
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [PW-1:0]     level_q, level_d;

    logic [DATA_W:0]   mem [DEPTH];
    logic              mem_we;
    logic              full;
    logic              pop;

    // Full uses the pre-pop read pointer, so a slot freed by a pop this
    // cycle only becomes usable next cycle.
    assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign out_valid = (cmt_ptr_q != rd_ptr_q);
    assign pop = out_valid & out_ready;
    assign {out_last, out_data} = mem[rd_ptr_q[AW-1:0]];

    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cmt_ptr_d    = cmt_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE, ACTIVE: begin
                if (rx_valid) begin
                    if (rx_last && rx_err) begin
                        // Errored packet: forget everything since the last commit.
                        wr_ptr_d     = cmt_ptr_q;
                        drop_pulse_d = 1'b1;
                        drop_cnt_d   = drop_cnt_q + CNT_W'(1);
                        state_d      = IDLE;
                    end else if (full) begin
                        // Packet cannot fit; drop it and skip its remaining beats.
                        wr_ptr_d     = cmt_ptr_q;
                        drop_pulse_d = 1'b1;
                        drop_cnt_d   = drop_cnt_q + CNT_W'(1);
                        state_d      = rx_last ? IDLE : DISCARD;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (rx_last) begin
                            cmt_ptr_d = wr_ptr_q + PW'(1);
                            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                            state_d   = IDLE;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (rx_valid && rx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        level_d = cmt_ptr_d - rd_ptr_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            cmt_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cmt_ptr_q    <= cmt_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            level_q      <= level_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are meaningful, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {rx_last, rx_data};
    end

    assign drop_pulse = drop_pulse_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign level      = level_q;

endmodule

// File: tb/tb_rdma_rx_pkt_buf.sv
// tb_rdma_rx_pkt_buf -- directed bench for rdma_rx_pkt_buf (DATA_W=64,
// DEPTH=16). Inputs change 1 time unit after the rising edge; a negedge
// monitor logs every accepted output beat.
module tb_rdma_rx_pkt_buf;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_last = 1'b0;
    logic              rx_err = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              drop_pulse;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [$clog2(DEPTH):0] level;

    int errors = 0;
    int checks = 0;
    bit rnd_ready = 1'b0;

    logic [DATA_W:0] cap_q[$];

    rdma_rx_pkt_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .drop_pulse(drop_pulse), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
        .level(level)
    );

    always #5 clk = ~clk;

    // Transfers happen at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) cap_q.push_back({out_last, out_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic e);
        rx_valid = 1'b1; rx_data = d; rx_last = l; rx_err = e;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse: got %b want 0", drop_pulse); end
    endtask

    task automatic test_good_packet();
        int base;
        logic [DATA_W:0] exp;
        do_reset();
        out_ready = 1'b1;
        base = cap_q.size();
        for (int i = 0; i < 3; i++) send_beat(64'h10 + 64'(i), 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_uncommitted_hidden: out_valid=%b want 0", out_valid); end
        send_beat(64'h13, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h10) begin
            errors++; $display("FAIL good_latency: out_valid=%b data=%h want 1/10", out_valid, out_data); end
        idle(8);
        checks++; if (cap_q.size() != base + 4) begin errors++; $display("FAIL good_beat_count: got %0d want 4", cap_q.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), 64'h10 + 64'(i)};
            checks++; if (cap_q[base+i] !== exp) begin errors++; $display("FAIL good_beat%0d: got %h want %h", i, cap_q[base+i], exp); end
        end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL good_pkt_cnt: got %0d want 1", pkt_cnt); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL good_level: got %0d want 0", level); end
    endtask

    task automatic test_err_drop();
        int base;
        logic [DATA_W:0] exp;
        do_reset();
        out_ready = 1'b1;
        base = cap_q.size();
        send_beat(64'hE0, 1'b0, 1'b1);   // error on non-last beat is ignored
        send_beat(64'hE1, 1'b0, 1'b0);
        send_beat(64'hE2, 1'b1, 1'b1);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL err_pulse_high: got %b want 1", drop_pulse); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL err_drop_cnt: got %0d want 1", drop_cnt); end
        idle(1);
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", drop_pulse); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_nothing_out: out_valid=%b want 0", out_valid); end
        send_beat(64'h20, 1'b0, 1'b0);
        send_beat(64'h21, 1'b1, 1'b0);
        idle(5);
        checks++; if (cap_q.size() != base + 2) begin errors++; $display("FAIL err_beat_count: got %0d want 2", cap_q.size() - base); end
        else for (int i = 0; i < 2; i++) begin
            exp = {(i == 1), 64'h20 + 64'(i)};
            checks++; if (cap_q[base+i] !== exp) begin errors++; $display("FAIL err_next_beat%0d: got %h want %h", i, cap_q[base+i], exp); end
        end
        checks++; if (pkt_cnt !== 16'd1 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL err_counters: pkt=%0d drop=%0d want 1/1", pkt_cnt, drop_cnt); end
    endtask

    task automatic test_overflow();
        int base;
        logic [DATA_W:0] exp;
        do_reset();
        out_ready = 1'b0;
        base = cap_q.size();
        for (int i = 0; i < 10; i++) send_beat(64'h30 + 64'(i), (i == 9), 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_beat(64'h40 + 64'(i), (i == 9), 1'b0);
            if (i == 5) begin
                checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ovf_early_drop: beat 6 pulse=%b want 0", drop_pulse); end
            end
            if (i == 6) begin
                checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL ovf_beat7_drop: pulse=%b want 1", drop_pulse); end
            end
        end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (level !== 5'd10) begin errors++; $display("FAIL ovf_level: got %0d want 10", level); end
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h30 || out_last !== 1'b0) begin
            errors++; $display("FAIL ovf_hold: v=%b d=%h l=%b want 1/30/0", out_valid, out_data, out_last); end
        send_beat(64'h50, 1'b1, 1'b0);  // fits into the space the drop rewound
        checks++; if (level !== 5'd11 || pkt_cnt !== 16'd2) begin
            errors++; $display("FAIL ovf_after_discard: level=%0d pkt=%0d want 11/2", level, pkt_cnt); end
        out_ready = 1'b1;
        idle(16);
        checks++; if (cap_q.size() != base + 11) begin errors++; $display("FAIL ovf_beat_count: got %0d want 11", cap_q.size() - base); end
        else for (int i = 0; i < 11; i++) begin
            exp = (i < 10) ? {(i == 9), 64'h30 + 64'(i)} : {1'b1, 64'h50};
            checks++; if (cap_q[base+i] !== exp) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, cap_q[base+i], exp); end
        end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_single_count: got %0d want 1", drop_cnt); end
    endtask

    task automatic test_long_packet();
        int base;
        int drop_at;
        do_reset();
        out_ready = 1'b1;
        base = cap_q.size();
        drop_at = 0;
        for (int i = 0; i < 20; i++) begin
            send_beat(64'h100 + 64'(i), (i == 19), 1'b0);
            if (drop_pulse === 1'b1 && drop_at == 0) drop_at = i + 1;
        end
        idle(4);
        checks++; if (drop_at != 17) begin errors++; $display("FAIL long_drop_beat: got %0d want 17", drop_at); end
        checks++; if (drop_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL long_counters: drop=%0d pkt=%0d want 1/0", drop_cnt, pkt_cnt); end
        checks++; if (cap_q.size() != base || out_valid !== 1'b0) begin
            errors++; $display("FAIL long_no_output: beats=%0d out_valid=%b want 0/0", cap_q.size() - base, out_valid); end
    endtask

    task automatic test_back_to_back();
        int base;
        int waited;
        logic [DATA_W:0] exp;
        do_reset();
        base = cap_q.size();
        rnd_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            waited = 0;
            while (level > 5'd13 && waited < 200) begin idle(1); waited++; end
            if (waited >= 200) begin
                checks++; errors++; $display("FAIL stream_drain_timeout: level=%0d want <=13", level);
            end
            for (int j = 0; j < 3; j++) send_beat(64'h1000 + 64'(p * 3 + j), (j == 2), 1'b0);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(24);
        checks++; if (cap_q.size() != base + 120) begin errors++; $display("FAIL stream_beat_count: got %0d want 120", cap_q.size() - base); end
        else for (int i = 0; i < 120; i++) begin
            exp = {(i % 3 == 2), 64'h1000 + 64'(i)};
            checks++; if (cap_q[base+i] !== exp) begin errors++; $display("FAIL stream_beat%0d: got %h want %h", i, cap_q[base+i], exp); end
        end
        checks++; if (pkt_cnt !== 16'd40 || drop_cnt !== 16'd0 || level !== 5'd0) begin
            errors++; $display("FAIL stream_counters: pkt=%0d drop=%0d level=%0d want 40/0/0", pkt_cnt, drop_cnt, level); end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        logic [DATA_W:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(64'h60 + 64'(i), (i == 2), 1'b0);
        send_beat(64'h63, 1'b0, 1'b0);
        send_beat(64'h64, 1'b0, 1'b0);
        checks++; if (level !== 5'd3 || pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL rstmid_pre: level=%0d pkt=%0d want 3/1", level, pkt_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 5'd0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_async: v=%b level=%0d pkt=%0d drop=%0d want 0/0/0/0", out_valid, level, pkt_cnt, drop_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        base = cap_q.size();
        send_beat(64'h70, 1'b0, 1'b0);
        send_beat(64'h71, 1'b1, 1'b0);
        idle(5);
        checks++; if (cap_q.size() != base + 2) begin errors++; $display("FAIL rstmid_beat_count: got %0d want 2", cap_q.size() - base); end
        else for (int i = 0; i < 2; i++) begin
            exp = {(i == 1), 64'h70 + 64'(i)};
            checks++; if (cap_q[base+i] !== exp) begin errors++; $display("FAIL rstmid_beat%0d: got %h want %h", i, cap_q[base+i], exp); end
        end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_err_drop();
        test_overflow();
        test_long_packet();
        test_back_to_back();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
